// File: rtl/bexkat1_ifetch_if.sv
// Bus and instruction-side signal bundle for the bexkat1 prefetch unit.
// master = prefetch unit, slave = Wishbone slave plus control unit.
interface bexkat1_ifetch_if;
  logic [31:0] bus_adr_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;
  logic        bus_stall_i;
  logic        ir_valid_o;
  logic [31:0] ir_o;
  logic [31:0] pc_o;
  logic        ir_ready_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;

  modport master (
    output bus_adr_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o,
    input  bus_dat_i, bus_ack_i, bus_stall_i,
    output ir_valid_o, ir_o, pc_o,
    input  ir_ready_i, flush_i, flush_pc_i
  );

  modport slave (
    input  bus_adr_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o,
    output bus_dat_i, bus_ack_i, bus_stall_i,
    input  ir_valid_o, ir_o, pc_o,
    output ir_ready_i, flush_i, flush_pc_i
  );
endinterface

// File: rtl/bexkat1_ifetch.sv
// bexkat1 instruction prefetch: sequential pipelined Wishbone reads into a
// small {pc, word} FIFO, with flush/redirect and draining of stale reads.
module bexkat1_ifetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk_i,
  input logic              rst_i,
  bexkat1_ifetch_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  localparam logic [0:0] S_IF_FETCH = 1'b0;
  localparam logic [0:0] S_IF_DRAIN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          run_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   ack_pc_q, ack_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [63:0]   mem_q [DEPTH];

  logic [CW:0]   occupancy;
  logic [31:0]   flush_pc;
  logic          credit, stb, accept, ack_ok, push, pop, valid;

  // Credit counts buffered plus in-flight words from registered state only,
  // so a word popped this cycle frees its slot one cycle later.
  always_comb begin
    flush_pc  = bus.flush_pc_i & 32'hFFFF_FFFC;
    occupancy = {1'b0, count_q} + {1'b0, outst_q};
    credit    = occupancy < DEPTH_W;
    valid     = count_q != '0;
    stb       = run_q && (state_q == S_IF_FETCH) && credit && !bus.flush_i;
    accept    = stb && !bus.bus_stall_i;
    ack_ok    = bus.bus_ack_i && (outst_q != '0);
    push      = ack_ok && (state_q == S_IF_FETCH) && !bus.flush_i;
    pop       = bus.ir_ready_i && valid && !bus.flush_i;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    ack_pc_d   = push ? ack_pc_q + 32'd4 : ack_pc_q;
    outst_d    = outst_q + CW'(accept) - CW'(ack_ok);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    if (state_q == S_IF_DRAIN && outst_d == '0) begin
      state_d = S_IF_FETCH;
    end

    // Flush wins over any same-cycle push or pop; reads still in flight
    // after this cycle's ack must be absorbed before fetching resumes.
    if (bus.flush_i) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = flush_pc;
      ack_pc_d   = flush_pc;
      state_d    = (outst_d != '0) ? S_IF_DRAIN : S_IF_FETCH;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IF_FETCH;
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      ack_pc_q   <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      ack_pc_q   <= ack_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {ack_pc_q, bus.bus_dat_i};
    end
  end

  assign bus.bus_adr_o  = fetch_pc_q;
  assign bus.bus_stb_o  = stb;
  assign bus.bus_cyc_o  = stb || (outst_q != '0);
  assign bus.bus_we_o   = 1'b0;
  assign bus.bus_sel_o  = 4'hf;
  assign bus.ir_valid_o = valid;
  assign bus.ir_o       = valid ? mem_q[rd_ptr_q][31:0] : '0;
  assign bus.pc_o       = valid ? mem_q[rd_ptr_q][63:32] : '0;
endmodule

// File: tb/tb_bexkat1_ifetch.sv
// Directed bench for bexkat1_ifetch: queue-based reference model checked
// every cycle, plus literal expectations per scenario.
module tb_bexkat1_ifetch;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bexkat1_ifetch_if ifc ();

  bexkat1_ifetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.master)
  );

  int checks = 0;
  int errors = 0;

  // stimulus configuration applied at the next step
  logic        cfg_stall, cfg_ready, cfg_flush, cfg_ack;
  logic [31:0] cfg_fpc;

  // reference model
  logic              m_run;
  logic [31:0]       m_fetch_pc;
  logic [31:0]       m_inflight[$];
  logic [63:0]       m_fifo[$];
  int unsigned       m_stale;

  // slave and observation logs
  logic [31:0] pend[$];
  logic [31:0] acc_log[$];
  logic [63:0] pop_log[$];
  int          cyc_n, first_ack, first_valid;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic compare_update();
    logic        exp_stb, exp_cyc, exp_valid, ackd, had;
    logic [31:0] a;
    logic [63:0] head;
    a         = '0;
    exp_stb   = m_run && (m_stale == 0) &&
                (m_fifo.size() + m_inflight.size() < DEPTH) && !ifc.flush_i;
    exp_cyc   = exp_stb || (m_inflight.size() != 0);
    exp_valid = m_fifo.size() != 0;
    chk("stb", ifc.bus_stb_o, exp_stb);
    chk("cyc", ifc.bus_cyc_o, exp_cyc);
    chk("adr", ifc.bus_adr_o, m_fetch_pc);
    chk("ir_valid", ifc.ir_valid_o, exp_valid);
    if (exp_valid) begin
      head = m_fifo[0];
      chk("pc", ifc.pc_o, head[63:32]);
      chk("ir", ifc.ir_o, head[31:0]);
    end

    cyc_n++;
    if (ifc.bus_ack_i && first_ack < 0) first_ack = cyc_n;
    if (ifc.ir_valid_o && first_valid < 0) first_valid = cyc_n;
    if (ifc.bus_stb_o && !ifc.bus_stall_i) acc_log.push_back(ifc.bus_adr_o);
    if (ifc.ir_valid_o && ifc.ir_ready_i && !ifc.flush_i)
      pop_log.push_back({ifc.pc_o, ifc.ir_o});

    if (ifc.bus_ack_i && m_inflight.size() == 0) begin
      errors++;
      $display("FAIL stray_ack actual=1 expected=0 t=%0t", $time);
    end

    ackd = ifc.bus_ack_i && (m_inflight.size() != 0);
    had  = m_fifo.size() != 0;
    if (ackd) a = m_inflight.pop_front();
    if (exp_stb && !ifc.bus_stall_i) begin
      m_inflight.push_back(m_fetch_pc);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (ifc.flush_i) begin
      m_fifo.delete();
      m_fetch_pc = ifc.flush_pc_i & ~32'h3;
      m_stale    = m_inflight.size();
    end else begin
      if (ackd) begin
        if (m_stale > 0) m_stale--;
        else m_fifo.push_back({a, memw(a)});
      end
      if (ifc.ir_ready_i && had) void'(m_fifo.pop_front());
    end
    m_run = 1'b1;

    if (ifc.bus_ack_i && pend.size() != 0) void'(pend.pop_front());
    if (ifc.bus_stb_o && !ifc.bus_stall_i) pend.push_back(ifc.bus_adr_o);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    ifc.bus_stall_i = cfg_stall;
    ifc.ir_ready_i  = cfg_ready;
    ifc.flush_i     = cfg_flush;
    ifc.flush_pc_i  = cfg_fpc;
    if (cfg_ack && pend.size() != 0) begin
      ifc.bus_ack_i = 1'b1;
      ifc.bus_dat_i = memw(pend[0]);
    end else begin
      ifc.bus_ack_i = 1'b0;
      ifc.bus_dat_i = '0;
    end
    @(negedge clk);
    compare_update();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.bus_stall_i = 1'b0;
    ifc.ir_ready_i  = 1'b0;
    ifc.flush_i     = 1'b0;
    ifc.flush_pc_i  = '0;
    ifc.bus_ack_i   = 1'b0;
    ifc.bus_dat_i   = '0;
    cfg_stall = 1'b0; cfg_ready = 1'b0; cfg_flush = 1'b0; cfg_ack = 1'b1;
    cfg_fpc   = '0;
    m_run = 1'b0; m_fetch_pc = RPC; m_stale = 0;
    m_inflight.delete(); m_fifo.delete(); pend.delete();
    acc_log.delete(); pop_log.delete();
    cyc_n = 0; first_ack = -1; first_valid = -1;
    repeat (2) @(negedge clk);
    chk("rst_stb", ifc.bus_stb_o, 1'b0);
    chk("rst_cyc", ifc.bus_cyc_o, 1'b0);
    chk("rst_adr", ifc.bus_adr_o, RPC);
    chk("rst_valid", ifc.ir_valid_o, 1'b0);
    chk("rst_ir", ifc.ir_o, 32'h0);
    chk("rst_pc", ifc.pc_o, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    compare_update();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    // sequential fetch with one-cycle acks
    do_reset();
    cfg_ready = 1'b1;
    steps(8);
    chk("seq_adr0", acc_log[0], 32'h100);
    chk("seq_adr1", acc_log[1], 32'h104);
    chk("seq_adr2", acc_log[2], 32'h108);
    chk("seq_pop0_pc", pop_log[0][63:32], 32'h100);
    chk("seq_pop0_ir", pop_log[0][31:0], memw(32'h100));
    chk("seq_pop1_pc", pop_log[1][63:32], 32'h104);
    chk("seq_latency", 32'(first_valid - first_ack), 32'd1);

    // credit limit with no consumer
    do_reset();
    steps(10);
    chk("credit_count", 32'(acc_log.size()), 32'd4);
    chk("credit_stb", ifc.bus_stb_o, 1'b0);
    chk("credit_cyc", ifc.bus_cyc_o, 1'b0);
    cfg_ready = 1'b1;
    step();
    cfg_ready = 1'b0;
    steps(6);
    chk("credit_pop_pc", pop_log[0][63:32], 32'h100);
    chk("credit_count2", 32'(acc_log.size()), 32'd5);
    chk("credit_adr4", acc_log[4], 32'h110);

    // stalled first strobe
    do_reset();
    cfg_stall = 1'b1;
    steps(3);
    chk("stall_none", 32'(acc_log.size()), 32'd0);
    chk("stall_adr", ifc.bus_adr_o, 32'h100);
    chk("stall_stb", ifc.bus_stb_o, 1'b1);
    cfg_stall = 1'b0;
    step();
    chk("stall_rel_adr", acc_log[0], 32'h100);
    steps(4);

    // flush with 1 buffered and 2 outstanding
    do_reset();
    step();
    step();
    cfg_ack = 1'b0;
    step();
    cfg_flush = 1'b1; cfg_fpc = 32'h2003;
    step();
    cfg_flush = 1'b0; cfg_ack = 1'b1;
    step();
    chk("flush_valid", ifc.ir_valid_o, 1'b0);
    chk("flush_drain_stb", ifc.bus_stb_o, 1'b0);
    steps(2);
    chk("flush_acc_n", 32'(acc_log.size()), 32'd4);
    chk("flush_new_adr", acc_log[3], 32'h2000);
    cfg_ready = 1'b1;
    steps(4);
    chk("flush_pop_pc", pop_log[0][63:32], 32'h2000);
    chk("flush_pop_ir", pop_log[0][31:0], memw(32'h2000));

    // flush coincident with ack and ready
    do_reset();
    cfg_ready = 1'b1;
    step();
    step();
    cfg_flush = 1'b1; cfg_fpc = 32'h300;
    step();
    cfg_flush = 1'b0;
    chk("fack_nopop", 32'(pop_log.size()), 32'd0);
    step();
    chk("fack_valid", ifc.ir_valid_o, 1'b0);
    chk("fack_adr", ifc.bus_adr_o, 32'h300);
    chk("fack_stb", ifc.bus_stb_o, 1'b1);
    steps(4);
    chk("fack_pop_pc", pop_log[0][63:32], 32'h300);

    // address wrap
    do_reset();
    cfg_ready = 1'b1;
    cfg_flush = 1'b1; cfg_fpc = 32'hFFFF_FFF8;
    step();
    cfg_flush = 1'b0;
    steps(8);
    chk("wrap_adr0", acc_log[0], 32'hFFFF_FFF8);
    chk("wrap_adr1", acc_log[1], 32'hFFFF_FFFC);
    chk("wrap_adr2", acc_log[2], 32'h0000_0000);
    chk("wrap_pop2_pc", pop_log[2][63:32], 32'h0000_0000);
    chk("wrap_pop2_ir", pop_log[2][31:0], memw(32'h0));

    // asynchronous reset during a stalled strobe with a read outstanding
    do_reset();
    cfg_ack = 1'b0;
    step();
    cfg_stall = 1'b1;
    step();
    chk("arst_cyc_before", ifc.bus_cyc_o, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_cyc", ifc.bus_cyc_o, 1'b0);
    chk("arst_stb", ifc.bus_stb_o, 1'b0);
    chk("arst_adr", ifc.bus_adr_o, RPC);
    do_reset();
    cfg_ready = 1'b1;
    steps(5);
    chk("arst_restart", acc_log[0], 32'h100);
    chk("arst_pop_pc", pop_log[0][63:32], 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
